// File: rtl/ddr3_bist_pkg.sv
// Shared types and constants for the DDR3 self-test traffic engine.
package ddr3_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WRITE,
    ST_READ,
    ST_PASS,
    ST_FAIL
  } state_t;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1:
  // feedback is the XOR of bits 0, 2, 3 and 5, entering at bit 15.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // An all-zero seed would lock the LFSR, so it is replaced.
  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/ddr3_bist_lfsr16.sv
// 16-bit Fibonacci LFSR pattern generator; load has priority over step.
module ddr3_bist_lfsr16
  import ddr3_bist_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  // Shift register: reload at run/phase start, advance once per accepted beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= DEFAULT_SEED;
    end else if (load) begin
      value <= seed;
    end else if (step) begin
      value <= {^(value & LFSR_TAPS), value[15:1]};
    end
  end

endmodule

// File: rtl/ddr3_bist.sv
// DDR3 self-test engine: writes a pattern block, reads it back, reports
// pass/fail and the first mismatching address/data.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_INIT | run latched, waiting for controller init complete
// WRITE     | offering write beats base+idx, payload pattern(idx)
// READ      | accepting read beats and comparing against pattern(idx)
// PASS      | whole block matched (or empty run); holds until start
// FAIL      | first mismatch captured in err_*; holds until start
module ddr3_bist
  import ddr3_bist_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              mode,
  input  logic [15:0]       seed,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic [DATA_W-1:0] err_exp,
  input  logic              mem_initFin,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_sel,
  output logic              mem_dataWr_valid,
  input  logic              mem_dataWr_ready,
  output logic [DATA_W-1:0] mem_dataWr_payload,
  output logic              mem_dataRd_ready,
  input  logic              mem_dataRd_valid,
  input  logic [DATA_W-1:0] mem_dataRd_payload
);

  state_t            state;
  logic              mode_q;
  logic [15:0]       seed_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;

  logic              start_ok;
  logic              wr_fire;
  logic              rd_fire;
  logic              last_beat;
  logic              match;
  logic              lfsr_load;
  logic              lfsr_step;
  logic [15:0]       lfsr_seed;
  logic [15:0]       lfsr_value;
  logic [DATA_W-1:0] pattern;

  // Handshake and pattern decode; only registered values reach mem_* outputs.
  always_comb begin
    start_ok  = start & ((state == ST_IDLE) | (state == ST_PASS) | (state == ST_FAIL));
    wr_fire   = mem_dataWr_valid & mem_dataWr_ready;
    rd_fire   = mem_dataRd_ready & mem_dataRd_valid;
    last_beat = (idx == (len_q - LEN_W'(1)));
    pattern   = mode_q ? DATA_W'(lfsr_value) : DATA_W'(idx[15:0]);
    match     = (mem_dataRd_payload == pattern);
    lfsr_load = start_ok | (wr_fire & last_beat);
    lfsr_seed = start_ok ? fix_seed(seed) : seed_q;
    lfsr_step = (wr_fire & ~last_beat) | (rd_fire & match & ~last_beat);
  end

  assign mem_address        = base_q + ADDR_W'(idx);
  assign mem_dataWr_payload = pattern;
  assign mem_sel            = 2'b11;

  ddr3_bist_lfsr16 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .load   (lfsr_load),
    .seed   (lfsr_seed),
    .step   (lfsr_step),
    .value  (lfsr_value)
  );

  // Sequencer with registered status and handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      mode_q           <= 1'b0;
      seed_q           <= DEFAULT_SEED;
      base_q           <= '0;
      len_q            <= '0;
      idx              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail             <= 1'b0;
      err_addr         <= '0;
      err_data         <= '0;
      err_exp          <= '0;
      mem_dataWr_valid <= 1'b0;
      mem_dataRd_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            mode_q   <= mode;
            seed_q   <= fix_seed(seed);
            base_q   <= base;
            len_q    <= len;
            idx      <= '0;
            err_addr <= '0;
            err_data <= '0;
            err_exp  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            state    <= ST_WAIT_INIT;
          end
        end
        ST_WAIT_INIT: begin
          if (mem_initFin) begin
            if (len_q == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
              state <= ST_PASS;
            end else begin
              mem_dataWr_valid <= 1'b1;
              state            <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (wr_fire) begin
            if (last_beat) begin
              idx              <= '0;
              mem_dataWr_valid <= 1'b0;
              mem_dataRd_ready <= 1'b1;
              state            <= ST_READ;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        ST_READ: begin
          if (rd_fire) begin
            if (!match) begin
              err_addr         <= mem_address;
              err_data         <= mem_dataRd_payload;
              err_exp          <= pattern;
              mem_dataRd_ready <= 1'b0;
              busy             <= 1'b0;
              done             <= 1'b1;
              fail             <= 1'b1;
              state            <= ST_FAIL;
            end else if (last_beat) begin
              mem_dataRd_ready <= 1'b0;
              busy             <= 1'b0;
              done             <= 1'b1;
              pass             <= 1'b1;
              state            <= ST_PASS;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_bist.sv
// Bench for ddr3_bist: memory/controller model plus a block-level model of
// the expected write/read traffic, checked on every cycle via tick().
module tb_ddr3_bist;

  localparam int AW = 27;
  localparam int DW = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          mode;
  logic [15:0]   seed;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          busy, done, pass, fail;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data, err_exp;
  logic          mem_initFin;
  logic [AW-1:0] mem_address;
  logic [1:0]    mem_sel;
  logic          mem_dataWr_valid, mem_dataWr_ready;
  logic [DW-1:0] mem_dataWr_payload;
  logic          mem_dataRd_ready, mem_dataRd_valid;
  logic [DW-1:0] mem_dataRd_payload;

  ddr3_bist #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .start              (start),
    .mode               (mode),
    .seed               (seed),
    .base               (base),
    .len                (len),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .fail               (fail),
    .err_addr           (err_addr),
    .err_data           (err_data),
    .err_exp            (err_exp),
    .mem_initFin        (mem_initFin),
    .mem_address        (mem_address),
    .mem_sel            (mem_sel),
    .mem_dataWr_valid   (mem_dataWr_valid),
    .mem_dataWr_ready   (mem_dataWr_ready),
    .mem_dataWr_payload (mem_dataWr_payload),
    .mem_dataRd_ready   (mem_dataRd_ready),
    .mem_dataRd_valid   (mem_dataRd_valid),
    .mem_dataRd_payload (mem_dataRd_payload)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [15:0]   exp_data [0:32767];
  logic [AW-1:0] run_base;
  int            run_len;
  int            wr_cnt, rd_cnt;
  logic          init_fin, stall_en, corrupt_en;
  logic [AW-1:0] corrupt_addr;
  logic [15:0]   mem [logic [AW-1:0]];
  logic [AW-1:0] wr_addr_log [0:3];
  logic [15:0]   wr_data_log [0:3];
  logic          prev_stall, phase_due, fail_due;
  logic [AW-1:0] prev_addr;
  logic [15:0]   prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int i);
    return AW'(run_base + AW'(i));
  endfunction

  function automatic logic [15:0] mem_read(input logic [AW-1:0] a);
    logic [15:0] v;
    v = mem.exists(a) ? mem[a] : 16'hDEAD;
    if (corrupt_en && a == corrupt_addr) v = v ^ 16'h8000;
    return v;
  endfunction

  // One cycle: drive the controller model, then check the beats the DUT
  // will complete at the next rising edge against the expected block.
  task automatic tick();
    @(negedge clk);
    if (prev_stall) begin
      chk("wr_hold_addr", mem_address, prev_addr);
      chk("wr_hold_data", mem_dataWr_payload, prev_data);
    end
    if (phase_due) begin
      chk("phase_wr_valid", mem_dataWr_valid, 0);
      chk("phase_rd_ready", mem_dataRd_ready, 1);
      phase_due = 1'b0;
    end
    if (fail_due) begin
      chk("mismatch_rd_ready", mem_dataRd_ready, 0);
      chk("mismatch_fail", fail, 1);
      chk("mismatch_done", done, 1);
      fail_due = 1'b0;
    end
    mem_initFin        = init_fin;
    mem_dataWr_ready   = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    mem_dataRd_valid   = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    mem_dataRd_payload = mem_read(mem_address);
    if (mem_dataWr_valid && mem_dataWr_ready) begin
      if (wr_cnt < run_len) begin
        chk("wr_addr", mem_address, exp_addr(wr_cnt));
        chk("wr_data", mem_dataWr_payload, exp_data[wr_cnt]);
        if (wr_cnt < 4) begin
          wr_addr_log[wr_cnt] = mem_address;
          wr_data_log[wr_cnt] = mem_dataWr_payload;
        end
        mem[mem_address] = mem_dataWr_payload;
      end else begin
        chk("extra_write", wr_cnt, run_len);
      end
      wr_cnt++;
      if (wr_cnt == run_len) phase_due = 1'b1;
    end
    if (mem_dataRd_ready && mem_dataRd_valid) begin
      if (rd_cnt < run_len) begin
        chk("rd_addr", mem_address, exp_addr(rd_cnt));
        if (corrupt_en && mem_address == corrupt_addr) fail_due = 1'b1;
      end else begin
        chk("extra_read", rd_cnt, run_len);
      end
      rd_cnt++;
    end
    prev_stall = mem_dataWr_valid && !mem_dataWr_ready;
    prev_addr  = mem_address;
    prev_data  = mem_dataWr_payload;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_wr_valid"}, mem_dataWr_valid, 0);
    chk({tag, "_rd_ready"}, mem_dataRd_ready, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_payload"}, mem_dataWr_payload, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
    chk({tag, "_err_data"}, err_data, 0);
    chk({tag, "_err_exp"}, err_exp, 0);
    chk({tag, "_sel"}, mem_sel, 2'b11);
  endtask

  task automatic start_run(input logic m, input logic [15:0] s, input logic [AW-1:0] b,
                           input int l, input logic st, input logic ce,
                           input logic [AW-1:0] ca);
    logic [15:0] v;
    v = (s == 16'h0) ? 16'hACE1 : s;
    for (int i = 0; i < l; i++) begin
      exp_data[i] = m ? v : 16'(i);
      v = lfsr_next(v);
    end
    run_base = b;  run_len = l;
    wr_cnt = 0;    rd_cnt = 0;
    stall_en = st; corrupt_en = ce; corrupt_addr = ca;
    mem.delete();
    prev_stall = 1'b0; phase_due = 1'b0; fail_due = 1'b0;
    mode = m; seed = s; base = b; len = LW'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_run(input int budget, input logic exp_pass);
    for (int k = 0; k < budget && !done; k++) tick();
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("run_pass", pass, exp_pass);
    chk("run_fail", fail, !exp_pass);
    if (exp_pass) begin
      chk("writes", wr_cnt, run_len);
      chk("reads", rd_cnt, run_len);
      chk("pass_err_addr", err_addr, 0);
      chk("pass_err_data", err_data, 0);
      chk("pass_err_exp", err_exp, 0);
    end
  endtask

  initial begin
    int cnt;
    resetn = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; base = '0; len = '0;
    mem_initFin = 1'b0; mem_dataWr_ready = 1'b0; mem_dataRd_valid = 1'b0;
    mem_dataRd_payload = '0;
    init_fin = 1'b0; stall_en = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
    run_base = '0; run_len = 0; wr_cnt = 0; rd_cnt = 0;
    prev_stall = 1'b0; phase_due = 1'b0; fail_due = 1'b0;
    prev_addr = '0; prev_data = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    // controller init held off for 100 cycles after start
    start_run(1'b0, 16'h0, '0, 8, 1'b0, 1'b0, '0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (mem_dataWr_valid) cnt++;
    end
    chk("no_wr_before_init", cnt, 0);
    chk("busy_waiting_init", busy, 1);
    init_fin = 1'b1;
    finish_run(200, 1'b1);

    // empty run
    start_run(1'b0, 16'h0, 27'd40, 0, 1'b0, 1'b0, '0);
    finish_run(50, 1'b1);

    // LFSR mode with zero seed, stalls
    start_run(1'b1, 16'h0, 27'h100, 64, 1'b1, 1'b0, '0);
    finish_run(1000, 1'b1);
    chk("lfsr_first", wr_data_log[0], 16'hACE1);
    chk("lfsr_second", wr_data_log[1], 16'h5670);

    // LFSR mode with explicit seed
    start_run(1'b1, 16'h1234, 27'h2000, 100, 1'b1, 1'b0, '0);
    finish_run(1500, 1'b1);
    chk("lfsr_seed_first", wr_data_log[0], 16'h1234);

    // address wrap
    start_run(1'b0, 16'h0, 27'h7FFFFFE, 4, 1'b0, 1'b0, '0);
    finish_run(50, 1'b1);
    chk("wrap_a0", wr_addr_log[0], 27'h7FFFFFE);
    chk("wrap_a1", wr_addr_log[1], 27'h7FFFFFF);
    chk("wrap_a2", wr_addr_log[2], 27'h0);
    chk("wrap_a3", wr_addr_log[3], 27'h1);

    // corrupted word at address 5
    start_run(1'b0, 16'h0, '0, 16, 1'b1, 1'b1, 27'd5);
    finish_run(500, 1'b0);
    chk("corrupt_writes", wr_cnt, 16);
    chk("corrupt_reads", rd_cnt, 6);
    chk("err_addr", err_addr, 27'd5);
    chk("err_exp", err_exp, 16'd5);
    chk("err_data", err_data, 16'h8005);
    tick();
    chk("fail_hold_rd_ready", mem_dataRd_ready, 0);
    chk("fail_hold", fail, 1);

    // reset in the middle of the write phase
    start_run(1'b0, 16'h0, 27'd100, 16, 1'b0, 1'b0, '0);
    for (int k = 0; k < 100 && wr_cnt < 5; k++) tick();
    chk("midrun_writing", mem_dataWr_valid, 1);
    #2 resetn = 1'b0;
    #1 chk_reset_outputs("midrun_reset");
    prev_stall = 1'b0; phase_due = 1'b0; fail_due = 1'b0;
    run_len = 0; wr_cnt = 0; rd_cnt = 0;
    tick();
    tick();
    chk_reset_outputs("after_reset");
    resetn = 1'b1;
    tick();
    chk("no_resume", busy, 0);
    start_run(1'b0, 16'h0, 27'd100, 16, 1'b0, 1'b0, '0);
    finish_run(200, 1'b1);
    chk("rerun_first_addr", wr_addr_log[0], 27'd100);
    chk("rerun_first_data", wr_data_log[0], 16'd0);

    // full 32768-beat block
    start_run(1'b0, 16'h0, '0, 32768, 1'b0, 1'b0, '0);
    finish_run(70000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
